conv_sched: RTL and testbench

CONV_SCHED -- requirements
Module: conv_sched

---
 rtl/conv_pkg.sv | 25 ++
 rtl/conv_sched.sv | 186 ++++++++++++++++++
 tb/tb_conv_sched.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/conv_pkg.sv
// Shared types and elaboration-time helpers for the convolution scheduler.
// Latency: none (package only).
// Backpressure: none (package only).
package conv_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_MAC   = 3'd2,
        S_DRAIN = 3'd3,
        S_WRITE = 3'd4,
        S_DONE  = 3'd5
    } state_e;

    // Number of valid outputs of a "valid" (no padding) 1-D convolution.
    function automatic int calc_nout(input int lenx, input int lenf);
        return lenx - lenf + 1;
    endfunction

    // Number of P-wide lane groups needed to cover all outputs.
    function automatic int calc_ngrp(input int nout, input int p);
        return (nout + p - 1) / p;
    endfunction

endpackage

// File: rtl/conv_sched.sv
// Sequences P parallel MAC lanes over a 1-D convolution, one lane group at a time.
// Latency: x_loaded -> clr_acc 1 cycle, first op_valid LENF+3 cycles; each further group LENF+3 cycles.
// Backpressure: WRITE holds op_valid/op_base/lane_mask and all addresses until op_ack is sampled.
module conv_sched
    import conv_pkg::*;
#(
    parameter int LENX  = 8,
    parameter int LENF  = 4,
    parameter int P     = 3,
    parameter int ADDRX = 3,
    parameter int ADDRF = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 x_loaded,
    input  logic                 op_ack,
    output logic [P*ADDRX-1:0]   x_addr,
    output logic [ADDRF-1:0]     f_addr,
    output logic                 clr_acc,
    output logic                 en_acc,
    output logic                 op_valid,
    output logic [ADDRX-1:0]     op_base,
    output logic [P-1:0]         lane_mask,
    output logic                 batch_done
);

    localparam int NOUT = calc_nout(LENX, LENF);
    localparam int NGRP = calc_ngrp(NOUT, P);
    localparam int GW   = (NGRP > 1) ? $clog2(NGRP) : 1;
    localparam int KW   = (LENF > 1) ? $clog2(LENF) : 1;

    localparam logic [GW-1:0] LAST_GRP = GW'(NGRP - 1);
    localparam logic [KW-1:0] LAST_K   = KW'(LENF - 1);

    // Lane address for tap k, clamped so masked lanes never read past the last sample.
    function automatic logic [ADDRX-1:0] lane_addr(input int b, input int i, input int k);
        int a;
        a = b + i + k;
        if (a > LENX - 1) begin
            a = LENX - 1;
        end
        return ADDRX'(a);
    endfunction

    function automatic logic [P*ADDRX-1:0] addr_vec(input int b, input int k);
        logic [P*ADDRX-1:0] v;
        v = '0;
        for (int i = 0; i < P; i++) begin
            v[i*ADDRX +: ADDRX] = lane_addr(b, i, k);
        end
        return v;
    endfunction

    // Lanes beyond the last real output in the final group are masked off.
    function automatic logic [P-1:0] mask_of(input int b);
        logic [P-1:0] m;
        m = '0;
        for (int i = 0; i < P; i++) begin
            m[i] = (b + i < NOUT);
        end
        return m;
    endfunction

    localparam logic [P*ADDRX-1:0] XADDR_RST = addr_vec(0, 0);

    state_e              state_q, state_d;
    logic [ADDRX-1:0]    base_q, base_d;
    logic [GW-1:0]       grp_q, grp_d;
    logic [KW-1:0]       k_q, k_d;
    logic [P*ADDRX-1:0]  x_addr_d;
    logic [ADDRF-1:0]    f_addr_d;
    logic                clr_acc_d;
    logic                en_acc_d;
    logic                op_valid_d;
    logic [ADDRX-1:0]    op_base_d;
    logic [P-1:0]        lane_mask_d;
    logic                batch_done_d;

    // Next state, then outputs derived from the next state so every output is a flop.
    always_comb begin
        state_d      = state_q;
        base_d       = base_q;
        grp_d        = grp_q;
        k_d          = k_q;
        x_addr_d     = x_addr;
        f_addr_d     = f_addr;
        clr_acc_d    = 1'b0;
        // Memory and ROM reads return one cycle after the address, so accumulate lags MAC by one.
        en_acc_d     = (state_q == S_MAC);
        op_valid_d   = 1'b0;
        op_base_d    = op_base;
        lane_mask_d  = '0;
        batch_done_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (x_loaded && !batch_done) begin
                    state_d = S_CLEAR;
                end
            end
            S_CLEAR: begin
                state_d = S_MAC;
                k_d     = '0;
            end
            S_MAC: begin
                if (k_q == LAST_K) begin
                    state_d = S_DRAIN;
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            S_DRAIN: begin
                state_d = S_WRITE;
            end
            S_WRITE: begin
                // x_loaded is deliberately not looked at here; only the ack moves us on.
                if (op_ack) begin
                    if (grp_q == LAST_GRP) begin
                        state_d = S_DONE;
                    end else begin
                        grp_d   = grp_q + GW'(1);
                        base_d  = base_q + ADDRX'(P);
                        state_d = S_CLEAR;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                base_d  = '0;
                grp_d   = '0;
            end
            default: begin
                state_d = S_IDLE;
                base_d  = '0;
                grp_d   = '0;
            end
        endcase

        case (state_d)
            S_CLEAR: clr_acc_d = 1'b1;
            S_MAC: begin
                x_addr_d = addr_vec(int'(base_d), int'(k_d));
                f_addr_d = ADDRF'(k_d);
            end
            S_WRITE: begin
                op_valid_d  = 1'b1;
                op_base_d   = base_d;
                lane_mask_d = mask_of(int'(base_d));
            end
            S_DONE:  batch_done_d = 1'b1;
            default: ;
        endcase
    end

    // State and registered outputs; reset abandons any group in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            base_q     <= '0;
            grp_q      <= '0;
            k_q        <= '0;
            x_addr     <= XADDR_RST;
            f_addr     <= '0;
            clr_acc    <= 1'b1;
            en_acc     <= 1'b0;
            op_valid   <= 1'b0;
            op_base    <= '0;
            lane_mask  <= '0;
            batch_done <= 1'b0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            grp_q      <= grp_d;
            k_q        <= k_d;
            x_addr     <= x_addr_d;
            f_addr     <= f_addr_d;
            clr_acc    <= clr_acc_d;
            en_acc     <= en_acc_d;
            op_valid   <= op_valid_d;
            op_base    <= op_base_d;
            lane_mask  <= lane_mask_d;
            batch_done <= batch_done_d;
        end
    end

endmodule

// File: tb/tb_conv_sched.sv
// Directed and randomised checks of the convolution scheduler with default parameters.
// Latency: cycle n is the period following rising edge n-1; x_loaded is sampled at edge 0.
// Backpressure: op_ack is driven directly to exercise WRITE stalls.
module tb_conv_sched;

    localparam int LENX  = 8;
    localparam int LENF  = 4;
    localparam int P     = 3;
    localparam int ADDRX = 3;
    localparam int ADDRF = 2;

    logic                clk = 1'b0;
    logic                reset = 1'b0;
    logic                x_loaded = 1'b0;
    logic                op_ack = 1'b0;
    logic [P*ADDRX-1:0]  x_addr;
    logic [ADDRF-1:0]    f_addr;
    logic                clr_acc;
    logic                en_acc;
    logic                op_valid;
    logic [ADDRX-1:0]    op_base;
    logic [P-1:0]        lane_mask;
    logic                batch_done;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    conv_sched #(
        .LENX  (LENX),
        .LENF  (LENF),
        .P     (P),
        .ADDRX (ADDRX),
        .ADDRF (ADDRF)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .x_loaded   (x_loaded),
        .op_ack     (op_ack),
        .x_addr     (x_addr),
        .f_addr     (f_addr),
        .clr_acc    (clr_acc),
        .en_acc     (en_acc),
        .op_valid   (op_valid),
        .op_base    (op_base),
        .lane_mask  (lane_mask),
        .batch_done (batch_done)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Packs lane addresses lane0..lane2 into the x_addr layout.
    function automatic logic [31:0] pk(input int a0, input int a1, input int a2);
        logic [8:0] v;
        v = {3'(a2), 3'(a1), 3'(a0)};
        return 32'(v);
    endfunction

    task automatic check_reset_vals(input string pfx);
        check_eq({pfx, "_xaddr"},  32'(x_addr),     pk(0, 1, 2));
        check_eq({pfx, "_faddr"},  32'(f_addr),     0);
        check_eq({pfx, "_clr"},    32'(clr_acc),    1);
        check_eq({pfx, "_en"},     32'(en_acc),     0);
        check_eq({pfx, "_vld"},    32'(op_valid),   0);
        check_eq({pfx, "_base"},   32'(op_base),    0);
        check_eq({pfx, "_mask"},   32'(lane_mask),  0);
        check_eq({pfx, "_done"},   32'(batch_done), 0);
    endtask

    initial begin
        int e_vld, e_done, e_clr, e_en;
        int en_cnt, groups, bd_seen;
        logic vld_prev, bd_prev;

        // ---- reset values ----
        #12;
        check_reset_vals("rst");
        @(posedge clk);
        #1;
        reset = 1'b1;
        step();
        check_eq("idle_clr", 32'(clr_acc), 0);
        check_eq("idle_vld", 32'(op_valid), 0);

        // ---- full batch, op_ack tied high, single x_loaded pulse at edge 0 ----
        op_ack   = 1'b1;
        x_loaded = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            step();
            x_loaded = 1'b0;
            e_vld  = (c == 7 || c == 14) ? 1 : 0;
            e_done = (c == 15) ? 1 : 0;
            e_clr  = (c == 1 || c == 8) ? 1 : 0;
            e_en   = ((c >= 3 && c <= 6) || (c >= 10 && c <= 13)) ? 1 : 0;
            check_eq($sformatf("t2_vld_c%0d", c),  32'(op_valid),   e_vld);
            check_eq($sformatf("t2_done_c%0d", c), 32'(batch_done), e_done);
            check_eq($sformatf("t2_clr_c%0d", c),  32'(clr_acc),    e_clr);
            check_eq($sformatf("t2_en_c%0d", c),   32'(en_acc),     e_en);
            case (c)
                2: begin
                    check_eq("t2_xaddr_g1k0", 32'(x_addr), pk(0, 1, 2));
                    check_eq("t2_faddr_g1k0", 32'(f_addr), 0);
                end
                5: begin
                    check_eq("t2_xaddr_g1k3", 32'(x_addr), pk(3, 4, 5));
                    check_eq("t2_faddr_g1k3", 32'(f_addr), 3);
                end
                7: begin
                    check_eq("t2_base_g1", 32'(op_base),   0);
                    check_eq("t2_mask_g1", 32'(lane_mask), 3'b111);
                end
                11: begin
                    check_eq("t2_xaddr_g2k2", 32'(x_addr), pk(5, 6, 7));
                    check_eq("t2_faddr_g2k2", 32'(f_addr), 2);
                end
                12: begin
                    check_eq("t2_xaddr_g2k3", 32'(x_addr), pk(6, 7, 7));
                    check_eq("t2_faddr_g2k3", 32'(f_addr), 3);
                end
                14: begin
                    check_eq("t2_base_g2", 32'(op_base),   3);
                    check_eq("t2_mask_g2", 32'(lane_mask), 3'b011);
                end
                default: ;
            endcase
        end

        // ---- op_ack in IDLE ignored ----
        step();
        step();
        check_eq("t3_idle_vld", 32'(op_valid), 0);
        check_eq("t3_idle_clr", 32'(clr_acc), 0);

        // ---- WRITE stall with x_loaded held high throughout ----
        x_loaded = 1'b1;
        op_ack   = 1'b0;
        step();
        check_eq("t3_clr", 32'(clr_acc), 1);
        for (int i = 0; i < 6; i++) step();
        check_eq("t3_vld",  32'(op_valid),  1);
        check_eq("t3_base", 32'(op_base),   0);
        check_eq("t3_mask", 32'(lane_mask), 3'b111);
        for (int i = 0; i < 10; i++) begin
            step();
            check_eq($sformatf("t3_hold_vld_%0d", i),   32'(op_valid),  1);
            check_eq($sformatf("t3_hold_base_%0d", i),  32'(op_base),   0);
            check_eq($sformatf("t3_hold_mask_%0d", i),  32'(lane_mask), 3'b111);
            check_eq($sformatf("t3_hold_xaddr_%0d", i), 32'(x_addr),    pk(3, 4, 5));
            check_eq($sformatf("t3_hold_faddr_%0d", i), 32'(f_addr),    3);
            check_eq($sformatf("t3_hold_en_%0d", i),    32'(en_acc),    0);
            check_eq($sformatf("t3_hold_clr_%0d", i),   32'(clr_acc),   0);
        end
        op_ack = 1'b1;
        step();
        check_eq("t3_ack_vld", 32'(op_valid), 0);
        check_eq("t3_ack_clr", 32'(clr_acc),  1);
        for (int i = 0; i < 6; i++) step();
        check_eq("t3_g2_vld",  32'(op_valid),  1);
        check_eq("t3_g2_base", 32'(op_base),   3);
        check_eq("t3_g2_mask", 32'(lane_mask), 3'b011);
        step();
        check_eq("t3_done",     32'(batch_done), 1);
        check_eq("t3_done_vld", 32'(op_valid),   0);
        step();
        check_eq("t3_idle_done", 32'(batch_done), 0);
        check_eq("t3_idle2_clr", 32'(clr_acc),    0);
        step();
        check_eq("t3_reclr",      32'(clr_acc),    1);
        check_eq("t3_reclr_done", 32'(batch_done), 0);
        x_loaded = 1'b0;

        // ---- reset during MAC of group 1 ----
        step();
        step();
        check_eq("t4_pre_xaddr", 32'(x_addr), pk(1, 2, 3));
        reset = 1'b0;
        #1;
        check_reset_vals("t4_async");
        step();
        check_reset_vals("t4_held");
        reset    = 1'b1;
        x_loaded = 1'b1;
        step();
        check_eq("t4_clr", 32'(clr_acc),  1);
        check_eq("t4_vld", 32'(op_valid), 0);
        x_loaded = 1'b0;
        step();
        check_eq("t4_xaddr", 32'(x_addr), pk(0, 1, 2));
        check_eq("t4_faddr", 32'(f_addr), 0);
        check_eq("t4_en",    32'(en_acc), 0);
        for (int i = 0; i < 5; i++) step();
        check_eq("t4_wvld",  32'(op_valid),  1);
        check_eq("t4_wbase", 32'(op_base),   0);
        check_eq("t4_wmask", 32'(lane_mask), 3'b111);
        op_ack  = 1'b1;
        bd_seen = 0;
        for (int i = 0; i < 20 && bd_seen == 0; i++) begin
            step();
            if (batch_done) bd_seen = 1;
        end
        check_eq("t4_done_seen", 32'(bd_seen), 1);

        // ---- random op_ack / x_loaded toggling ----
        en_cnt   = 0;
        groups   = 0;
        vld_prev = 1'b0;
        bd_prev  = 1'b0;
        for (int i = 0; i < 400; i++) begin
            x_loaded = 1'($urandom_range(0, 1));
            op_ack   = ($urandom_range(0, 2) == 0);
            step();
            check_eq($sformatf("t5_excl_%0d", i), 32'(clr_acc & en_acc), 0);
            check_eq($sformatf("t5_bd_pulse_%0d", i), 32'(batch_done & bd_prev), 0);
            if (clr_acc) en_cnt = 0;
            if (en_acc)  en_cnt++;
            if (op_valid && !vld_prev) begin
                groups++;
                check_eq($sformatf("t5_en_cnt_g%0d", groups), 32'(en_cnt), LENF);
            end
            vld_prev = op_valid;
            bd_prev  = batch_done;
        end
        check_eq("t5_groups_seen", 32'(groups > 0), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
